// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  // Four BCD digits, most significant first.
  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } mmss_t;

  // Keypad entry: shift left one digit, new digit enters at seconds ones.
  function automatic mmss_t shift_in(mmss_t cur, logic [3:0] dig);
    mmss_t res;
    res.min_tens = cur.min_ones;
    res.min_ones = cur.sec_tens;
    res.sec_tens = cur.sec_ones;
    res.sec_ones = dig;
    return res;
  endfunction

  function automatic logic is_zero(mmss_t v);
    return (v == '0);
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of the ripple-borrow decrementer.
module bcd_digit_down (
  input  logic [3:0] i_digit,
  input  logic       i_borrow,
  input  logic [3:0] i_wrap,
  output logic [3:0] o_digit,
  output logic       o_borrow
);

  // Decrement when borrowed from; a zero digit wraps and passes the borrow on.
  always_comb begin
    o_digit  = i_digit;
    o_borrow = 1'b0;
    if (i_borrow) begin
      if (i_digit == 4'd0) begin
        o_digit  = i_wrap;
        o_borrow = 1'b1;
      end else begin
        o_digit = i_digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/timer_countdown.sv
// MM:SS setpoint entry and 1 Hz countdown with pause, clear and done states.
module timer_countdown
  import timer_pkg::*;
#(
  parameter logic [3:0] SEC_TENS_WRAP = SEC_TENS_MAX,
  parameter logic [3:0] DIGIT_WRAP    = BCD_MAX
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_d,
  input  logic       i_loadn,
  input  logic       i_pgt_1hz,
  input  logic       i_startn,
  input  logic       i_stopn,
  input  logic       i_clearn,
  output logic [3:0] o_sec_ones,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_min_ones,
  output logic [3:0] o_min_tens,
  output logic       o_zero,
  output logic       o_running
);

  state_e r_state;
  state_e w_state_d;
  mmss_t  r_digits;
  mmss_t  w_digits_d;
  mmss_t  w_shifted;
  mmss_t  w_dec;
  logic   r_zero;
  logic   r_running;
  logic   r_loadn_q;
  logic   r_tick_q;
  logic   w_load_ev;
  logic   w_tick_ev;
  logic   w_load_ok;
  logic   w_b_so;
  logic   w_b_st;
  logic   w_b_mo;
  logic   w_underflow;

  assign w_load_ev = r_loadn_q & ~i_loadn;
  assign w_tick_ev = ~r_tick_q & i_pgt_1hz;
  // Non-BCD codes from the keypad are dropped.
  assign w_load_ok = w_load_ev & (i_d <= BCD_MAX);
  assign w_shifted = shift_in(r_digits, i_d);

  bcd_digit_down u_sec_ones (
    .i_digit  (r_digits.sec_ones),
    .i_borrow (1'b1),
    .i_wrap   (DIGIT_WRAP),
    .o_digit  (w_dec.sec_ones),
    .o_borrow (w_b_so)
  );

  bcd_digit_down u_sec_tens (
    .i_digit  (r_digits.sec_tens),
    .i_borrow (w_b_so),
    .i_wrap   (SEC_TENS_WRAP),
    .o_digit  (w_dec.sec_tens),
    .o_borrow (w_b_st)
  );

  bcd_digit_down u_min_ones (
    .i_digit  (r_digits.min_ones),
    .i_borrow (w_b_st),
    .i_wrap   (DIGIT_WRAP),
    .o_digit  (w_dec.min_ones),
    .o_borrow (w_b_mo)
  );

  bcd_digit_down u_min_tens (
    .i_digit  (r_digits.min_tens),
    .i_borrow (w_b_mo),
    .i_wrap   (DIGIT_WRAP),
    .o_digit  (w_dec.min_tens),
    .o_borrow (w_underflow)
  );

  // Next-state and next-digit decode; priority clear > stop > start > load/tick.
  always_comb begin
    w_state_d  = r_state;
    w_digits_d = r_digits;
    if (!i_clearn) begin
      w_digits_d = '0;
      w_state_d  = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_load_ok) begin
            w_digits_d = w_shifted;
          end
          // Start sees the post-load digits so load+start in one cycle works.
          if (i_stopn && !i_startn && !is_zero(w_digits_d)) begin
            w_state_d = StRun;
          end
        end
        StRun: begin
          if (!i_stopn) begin
            w_state_d = StIdle;
          end else if (w_tick_ev) begin
            // Underflow cannot occur from a nonzero count; clamp defensively.
            if (w_underflow) begin
              w_digits_d = '0;
              w_state_d  = StDone;
            end else begin
              w_digits_d = w_dec;
              if (is_zero(w_dec)) begin
                w_state_d = StDone;
              end
            end
          end
        end
        StDone: begin
          if (i_stopn && w_load_ok) begin
            w_digits_d = w_shifted;
            w_state_d  = StIdle;
          end
        end
        default: begin
          w_digits_d = '0;
          w_state_d  = StIdle;
        end
      endcase
    end
  end

  // State, digit and flag registers plus edge-detect history.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_digits  <= '0;
      r_zero    <= 1'b1;
      r_running <= 1'b0;
      r_loadn_q <= 1'b1;
      r_tick_q  <= 1'b1;
    end else begin
      r_state   <= w_state_d;
      r_digits  <= w_digits_d;
      r_zero    <= is_zero(w_digits_d);
      r_running <= (w_state_d == StRun);
      r_loadn_q <= i_loadn;
      r_tick_q  <= i_pgt_1hz;
    end
  end

  assign o_sec_ones = r_digits.sec_ones;
  assign o_sec_tens = r_digits.sec_tens;
  assign o_min_ones = r_digits.min_ones;
  assign o_min_tens = r_digits.min_tens;
  assign o_zero     = r_zero;
  assign o_running  = r_running;

endmodule

// File: tb/tb_timer_countdown.sv
// Directed bench for timer_countdown with a per-cycle behavioural reference.
module tb_timer_countdown;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d;
  logic       loadn, pgt, startn, stopn, clearn;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       zero, running;

  int n_vec  = 0;
  int n_fail = 0;

  timer_countdown dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_d        (d),
    .i_loadn    (loadn),
    .i_pgt_1hz  (pgt),
    .i_startn   (startn),
    .i_stopn    (stopn),
    .i_clearn   (clearn),
    .o_sec_ones (sec_ones),
    .o_sec_tens (sec_tens),
    .o_min_ones (min_ones),
    .o_min_tens (min_tens),
    .o_zero     (zero),
    .o_running  (running)
  );

  always #5 clk = ~clk;

  // Reference: digits [0]=sec ones .. [3]=min tens; mode 0 idle, 1 run, 2 done.
  logic [3:0] m_dig [4];
  int         m_mode;
  logic       m_zero, m_run, m_loadn_p, m_tick_p;
  logic       m_valid = 1'b0;

  always @(posedge clk) begin
    automatic logic [3:0] nd [4];
    automatic int  nmode;
    automatic bit  lev, tev, nz;
    automatic int  k;
    if (rst) begin
      m_dig     <= '{default: 4'd0};
      m_mode    <= 0;
      m_zero    <= 1'b1;
      m_run     <= 1'b0;
      m_loadn_p <= 1'b1;
      m_tick_p  <= 1'b1;
      m_valid   <= 1'b1;
    end else begin
      lev   = m_loadn_p && !loadn && (d <= 4'd9);
      tev   = !m_tick_p && pgt;
      nd    = m_dig;
      nmode = m_mode;
      if (!clearn) begin
        nd    = '{default: 4'd0};
        nmode = 0;
      end else if (m_mode == 0) begin
        if (lev) nd = '{d, m_dig[0], m_dig[1], m_dig[2]};
        nz = (nd[0] | nd[1] | nd[2] | nd[3]) != 4'd0;
        if (stopn && !startn && nz) nmode = 1;
      end else if (m_mode == 1) begin
        if (!stopn) begin
          nmode = 0;
        end else if (tev) begin
          // Lowest nonzero digit drops by one, every digit below it goes to its max.
          k = -1;
          for (int i = 0; i < 4; i++) if (k < 0 && nd[i] != 4'd0) k = i;
          for (int i = 0; i < 4; i++) if (i < k) nd[i] = (i == 1) ? 4'd5 : 4'd9;
          if (k >= 0) nd[k] = nd[k] - 4'd1;
          if ((nd[0] | nd[1] | nd[2] | nd[3]) == 4'd0) nmode = 2;
        end
      end else begin
        if (stopn && lev) begin
          nd    = '{d, m_dig[0], m_dig[1], m_dig[2]};
          nmode = 0;
        end
      end
      m_dig     <= nd;
      m_mode    <= nmode;
      m_zero    <= (nd[0] | nd[1] | nd[2] | nd[3]) == 4'd0;
      m_run     <= (nmode == 1);
      m_loadn_p <= loadn;
      m_tick_p  <= pgt;
    end
  end

  wire [15:0] dut_v = {min_tens, min_ones, sec_tens, sec_ones};
  wire [15:0] mod_v = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};

  // Every cycle after reset the DUT must track the reference exactly.
  always @(negedge clk) begin
    if (m_valid) begin
      n_vec++;
      if (dut_v !== mod_v || zero !== m_zero || running !== m_run) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t: got %h z=%b r=%b, want %h z=%b r=%b",
                 $time, dut_v, zero, running, mod_v, m_zero, m_run);
      end
    end
  end

  // Hand-computed expectation, applied to both DUT and reference.
  task automatic check_lit(input string name, input logic [15:0] ev, input logic ez,
                           input logic er);
    n_vec++;
    if (dut_v !== ev || zero !== ez || running !== er) begin
      n_fail++;
      $display("FAIL %s dut: got %h z=%b r=%b, want %h z=%b r=%b",
               name, dut_v, zero, running, ev, ez, er);
    end
    n_vec++;
    if (mod_v !== ev || m_zero !== ez || m_run !== er) begin
      n_fail++;
      $display("FAIL %s model: got %h z=%b r=%b, want %h z=%b r=%b",
               name, mod_v, m_zero, m_run, ev, ez, er);
    end
  endtask

  task automatic key(input logic [3:0] v);
    @(negedge clk); d = v; loadn = 1'b0;
    @(negedge clk); loadn = 1'b1;
    @(negedge clk);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); pgt = 1'b1;
      @(negedge clk); pgt = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic start_pulse();
    @(negedge clk); startn = 1'b0;
    @(negedge clk); startn = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_pulse();
    @(negedge clk); clearn = 1'b0;
    @(negedge clk); clearn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; d = 4'd0; loadn = 1'b1; pgt = 1'b1;
    startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_lit("reset", 16'h0000, 1'b1, 1'b0);
    pgt = 1'b0;

    key(4'd1); key(4'd3); key(4'd0);
    check_lit("entry_0130", 16'h0130, 1'b0, 1'b0);
    key(4'hA);
    check_lit("entry_nonbcd", 16'h0130, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) key(4'(i));
    check_lit("entry_2345", 16'h2345, 1'b0, 1'b0);

    clear_pulse();
    key(4'd1); key(4'd0); key(4'd0);
    start_pulse();
    check_lit("start_0100", 16'h0100, 1'b0, 1'b1);
    tick(1);
    check_lit("borrow_0059", 16'h0059, 1'b0, 1'b1);
    tick(58);
    check_lit("tick59_0001", 16'h0001, 1'b0, 1'b1);
    tick(1);
    check_lit("tick60_done", 16'h0000, 1'b1, 1'b0);
    tick(1);
    check_lit("done_extra_tick", 16'h0000, 1'b1, 1'b0);
    start_pulse();
    check_lit("done_start_ign", 16'h0000, 1'b1, 1'b0);

    key(4'd1); key(4'd0);
    check_lit("done_reload", 16'h0010, 1'b0, 1'b0);
    start_pulse();
    tick(3);
    check_lit("run_0007", 16'h0007, 1'b0, 1'b1);
    key(4'd5);
    check_lit("run_load_ign", 16'h0007, 1'b0, 1'b1);
    @(negedge clk); stopn = 1'b0; pgt = 1'b1;
    @(negedge clk); stopn = 1'b1; pgt = 1'b0;
    @(negedge clk);
    check_lit("stop_beats_tick", 16'h0007, 1'b0, 1'b0);
    start_pulse();
    tick(1);
    check_lit("resume_0006", 16'h0006, 1'b0, 1'b1);

    @(negedge clk); d = 4'd3; loadn = 1'b0; clearn = 1'b0;
    @(negedge clk); loadn = 1'b1; clearn = 1'b1;
    @(negedge clk);
    check_lit("clear_beats_load", 16'h0000, 1'b1, 1'b0);
    start_pulse();
    check_lit("start_at_zero", 16'h0000, 1'b1, 1'b0);

    @(negedge clk); d = 4'd4; loadn = 1'b0; startn = 1'b0;
    @(negedge clk); loadn = 1'b1; startn = 1'b1;
    @(negedge clk);
    check_lit("load_and_start", 16'h0004, 1'b0, 1'b1);
    clear_pulse();

    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    start_pulse();
    tick(1);
    check_lit("wrap_0959", 16'h0959, 1'b0, 1'b1);
    clear_pulse();
    key(4'd7); key(4'd5);
    start_pulse();
    tick(1);
    check_lit("nonnorm_0074", 16'h0074, 1'b0, 1'b1);
    tick(15);
    check_lit("nonnorm_0059", 16'h0059, 1'b0, 1'b1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_countdown.md
Name: timer_countdown

Overview:
- Consumer side of the keypad/timer-control interface; receives BCD digits `d`, the active-low valid strobe `loadn` and the 1 Hz tick `pgt_1Hz`.
- Builds an MM:SS setpoint by shifting keyed digits in from the right, then counts down once per 1 Hz tick to 00:00.
- Sits between the keypad/timer-control front end and the display/magnetron control.
- Provides four BCD digit outputs plus zero and running flags.

Parameters:
- SEC_TENS_WRAP, 5, value loaded into the seconds-tens digit on borrow.
- DIGIT_WRAP, 9, value loaded into ones digits and minutes-tens on borrow.

Ports:
- clk  input  1  system clock; all inputs are synchronous to it.
- rst  input  1  synchronous reset, active-high.
- d  input  4  BCD digit from the keypad encoder.
- loadn  input  1  active-low data-valid; a high-to-low transition enters one digit.
- pgt_1Hz  input  1  1 Hz tick, a level synchronous to clk; its rising edge is one tick.
- startn  input  1  active-low start request.
- stopn  input  1  active-low stop/pause request.
- clearn  input  1  active-low clear of the setpoint and count.
- sec_ones  output  4  BCD seconds ones.
- sec_tens  output  4  BCD seconds tens.
- min_ones  output  4  BCD minutes ones.
- min_tens  output  4  BCD minutes tens.
- zero  output  1  high when all four digits are 0.
- running  output  1  high in RUN state.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All digits = 0, state = IDLE, zero = 1, running = 0.
  - Edge-detect registers load their inactive values: loadn_q = 1, tick_q = 1, so no spurious edge occurs after reset.
- Edge detection:
  - load_ev = loadn_q & ~loadn.
  - tick_ev = ~tick_q & pgt_1Hz.
  - Both registered every cycle.
- All outputs are registered. An event seen in cycle N is reflected on the outputs in cycle N+1.
- FSM IDLE (accept entry):
  - On load_ev with d <= 9: shift left. min_tens <= min_ones, min_ones <= sec_tens, sec_tens <= sec_ones, sec_ones <= d. The old min_tens is discarded.
  - d > 9 on load_ev: ignored, no change.
  - ~startn and digits != 0: go to RUN.
  - ~startn and digits == 0: stay in IDLE.
- FSM RUN (countdown):
  - tick_ev decrements MM:SS by one second, BCD ripple borrow:
    - sec_ones 0 -> DIGIT_WRAP with borrow into sec_tens.
    - sec_tens 0 -> SEC_TENS_WRAP with borrow into min_ones.
    - min_ones 0 -> 9 with borrow into min_tens.
  - A nonzero digit simply decrements. Entered values such as 00:75 count 75, 74 ... 60, 59 (no normalisation).
  - When the decrement result is 00:00, go to DONE in the same edge.
  - load_ev is ignored in RUN.
  - ~stopn: go to IDLE with digits held (pause). A later startn resumes from the held value.
- FSM DONE:
  - Digits stay 00:00, zero = 1, ticks are ignored.
  - load_ev (valid d): shift in as in IDLE and go to IDLE.
  - startn is ignored.
- clearn low (any state): digits = 0, go to IDLE.
- Priority, highest first: rst > clearn > stopn > startn > load_ev/tick_ev.
  - stopn and tick_ev in the same cycle: stop wins, no decrement.
  - startn and load_ev in the same cycle in IDLE: the load is applied and the transition uses the post-load digits.
- zero is registered and equals (next digits == 0). It is never asserted in RUN except in the transition cycle into DONE.
- running = (state == RUN).
- At most one decrement per tick_ev. pgt_1Hz held high produces no further ticks.

Decomposition:
- Shared package `timer_pkg`:
  - State typedef with encodings IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - BCD_MAX = 4'd9.
  - SEC_TENS_MAX = 4'd5.
- One sub-module `bcd_digit_down`:
  - Inputs: digit, borrow_in, wrap value.
  - Outputs: next digit, borrow_out.
  - Instantiated four times in a ripple chain.
- The FSM, edge detectors and shift register stay in the top.

Test Plan:
- Reset -> digits 00:00, zero=1, running=0. pgt_1Hz high immediately after reset produces no tick.
- Key entry: loadn pulses with d=1,3,0 -> after the last pulse, digits 01:30. d=4'hA pulse -> unchanged. Five pulses d=1..5 -> 23:45 (digit 1 dropped).
- Countdown borrow: load 01:00, startn pulse, one tick -> 00:59. Continue ticks to 00:00 -> state DONE, zero=1, running=0 exactly on the 60th tick. An extra tick leaves the value unchanged.
- Pause/resume: 00:10 running, 3 ticks -> 00:07. stopn together with a tick -> still 00:07, running=0. loadn during RUN before stop is ignored. startn -> resumes, next tick gives 00:06.
- Clear/priority: clearn and load_ev in the same cycle -> 00:00 in IDLE. startn at 00:00 -> stays IDLE.
- Wrap: load 10:00, run 1 tick -> 09:59. Load 00:75, 16 ticks -> 00:59.
